// File: rtl/reg_file_pkg.sv
// Shared definitions for the two-port register file: the sweep FSM state
// encoding and the default geometry.
package reg_file_pkg;

  typedef enum logic {
    CLEARING = 1'b0,
    READY    = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 32;

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear-sweep sequencer for reg_file_2p. Walks addr from 0 to DEPTH-1,
// one word per cycle, while busy is high. It starts after reset and
// restarts whenever start is seen in READY.
module reg_file_clr_seq
  import reg_file_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          start,
  output logic          busy,
  output logic [AW-1:0] addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_next;

  // State and sweep counter registers; reset restarts the sweep at word 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= CLEARING;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: advance the sweep, or hold READY until start.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      CLEARING: begin
        if (cnt == LAST) begin
          state_next = READY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + AW'(1);
        end
      end
      READY: begin
        if (start) begin
          state_next = CLEARING;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = CLEARING;
        cnt_next   = '0;
      end
    endcase
  end

  assign busy = (state == CLEARING);
  assign addr = cnt;

endmodule

// File: rtl/reg_file_2p.sv
// Two-port (one write, one read) register file with a registered read,
// write-first bypass, range checking, and a zeroing sweep that runs after
// reset and on CLR. Optional even-parity protection is enabled by
// defining REG_FILE_2P_PARITY_EN.
//
// Handshake: a request is accepted only when CS is low and BUSY is low.
// The read response (RDATA, RVALID, PERR) and the ERR pulse appear exactly
// one cycle after the accepted request. No back-pressure is applied.
module reg_file_2p
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CS,
  input  logic             WE,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH-1:0] WDATA,
  input  logic             RE,
  input  logic [AW-1:0]    RADDR,
  input  logic             CLR,
  input  logic             PINJ,
  output logic [WIDTH-1:0] RDATA,
  output logic             RVALID,
  output logic             BUSY,
  output logic             ERR,
  output logic             PERR
);

  // Compare addresses one bit wider so the range check is meaningful even
  // when DEPTH is a power of two.
  localparam logic [AW:0] DEPTH_X = (AW + 1)'(DEPTH);

  logic             sel;
  logic             wr_req;
  logic             rd_req;
  logic             wr_in;
  logic             rd_in;
  logic             wr_en;
  logic             bypass;
  logic [AW-1:0]    sweep_addr;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] mem [DEPTH];

  assign sel    = !BUSY && !CS;
  assign wr_req = sel && WE;
  assign rd_req = sel && RE;
  assign wr_in  = ({1'b0, WADDR} < DEPTH_X);
  assign rd_in  = ({1'b0, RADDR} < DEPTH_X);
  assign wr_en  = wr_req && wr_in;
  assign bypass = wr_en && (WADDR == RADDR);

  reg_file_clr_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_seq (
    .CLK   (CLK),
    .RST_N (RST_N),
    .start (sel && CLR),
    .busy  (BUSY),
    .addr  (sweep_addr)
  );

  // Array storage: the sweep owns the write port while busy.
  always_ff @(posedge CLK) begin
    if (BUSY) begin
      mem[sweep_addr] <= '0;
    end else if (wr_en) begin
      mem[WADDR] <= WDATA;
    end
  end

  // Read word selection with write-first bypass.
  always_comb begin
    rd_word = mem[RADDR];
    if (bypass) begin
      rd_word = WDATA;
    end
  end

  // Registered read response and out-of-range error pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RDATA  <= '0;
      RVALID <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      RVALID <= rd_req;
      ERR    <= (wr_req && !wr_in) || (rd_req && !rd_in);
      if (rd_req) begin
        RDATA <= rd_in ? rd_word : '0;
      end
    end
  end

`ifdef REG_FILE_2P_PARITY_EN
  logic par_mem [DEPTH];
  logic rd_par;
  logic wr_par;

  assign wr_par = (^WDATA) ^ PINJ;

  // Parity storage follows the data array; zero words carry parity 0.
  always_ff @(posedge CLK) begin
    if (BUSY) begin
      par_mem[sweep_addr] <= 1'b0;
    end else if (wr_en) begin
      par_mem[WADDR] <= wr_par;
    end
  end

  // Stored parity of the word being read, bypassed like the data.
  always_comb begin
    rd_par = par_mem[RADDR];
    if (bypass) begin
      rd_par = wr_par;
    end
  end

  // Parity error flag, valid alongside RVALID.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PERR <= 1'b0;
    end else begin
      PERR <= rd_req && rd_in && (rd_par != (^rd_word));
    end
  end
`else
  logic unused_pinj;
  assign unused_pinj = PINJ;
  assign PERR        = 1'b0;
`endif

endmodule

// File: tb/tb_reg_file_2p.sv
// Directed bench for reg_file_2p. A default instance (DEPTH=32) and a
// DEPTH=20 instance share all inputs so the out-of-range path can be hit
// with addresses that are legal for the larger instance.
module tb_reg_file_2p;

`ifdef REG_FILE_2P_PARITY_EN
  localparam logic PAR = 1'b1;
`else
  localparam logic PAR = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       CS, WE, RE, CLR, PINJ;
  logic [4:0] WADDR, RADDR;
  logic [7:0] WDATA;

  logic [7:0] rdata, rdata20;
  logic       rvalid, busy, err, perr;
  logic       rvalid20, busy20, err20, perr20;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic       cs;
    logic       we;
    logic [4:0] waddr;
    logic [7:0] wdata;
    logic       re;
    logic [4:0] raddr;
    logic       exp_rvalid;
    logic [7:0] exp_rdata;
    logic       exp_err;
    logic       exp_err20;
  } vec_t;

  vec_t vecs[10];

  reg_file_2p dut (
    .CLK(CLK), .RST_N(RST_N), .CS(CS), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .RE(RE), .RADDR(RADDR), .CLR(CLR), .PINJ(PINJ),
    .RDATA(rdata), .RVALID(rvalid), .BUSY(busy), .ERR(err), .PERR(perr)
  );

  reg_file_2p #(.DEPTH(20)) dut20 (
    .CLK(CLK), .RST_N(RST_N), .CS(CS), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .RE(RE), .RADDR(RADDR), .CLR(CLR), .PINJ(PINJ),
    .RDATA(rdata20), .RVALID(rvalid20), .BUSY(busy20), .ERR(err20), .PERR(perr20)
  );

  // Clock and watchdog.
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t mk(input logic cs, input logic we, input logic [4:0] wa,
                              input logic [7:0] wd, input logic re, input logic [4:0] ra,
                              input logic ev, input logic [7:0] ed, input logic ee,
                              input logic ee20);
    vec_t v;
    v.cs = cs; v.we = we; v.waddr = wa; v.wdata = wd; v.re = re; v.raddr = ra;
    v.exp_rvalid = ev; v.exp_rdata = ed; v.exp_err = ee; v.exp_err20 = ee20;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle();
    CS = 1'b1; WE = 1'b0; RE = 1'b0; CLR = 1'b0; PINJ = 1'b0;
    WADDR = '0; RADDR = '0; WDATA = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [7:0] d, input logic inj);
    idle();
    CS = 1'b0; WE = 1'b1; WADDR = a; WDATA = d; PINJ = inj;
    tick();
    idle();
  endtask

  task automatic read_check(input string name, input logic [4:0] a, input logic [7:0] d);
    idle();
    CS = 1'b0; RE = 1'b1; RADDR = a;
    tick();
    check({name, "_rvalid"}, 64'(rvalid), 64'(1'b1));
    check({name, "_rdata"}, 64'(rdata), 64'(d));
    idle();
  endtask

  // Counts edges while the default instance stays busy, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int n20;
    int guard;
    logic bad;

    vecs[0] = mk(1'b0, 1'b1, 5'd5,  8'hA5, 1'b1, 5'd5,  1'b1, 8'hA5, 1'b0, 1'b0);
    vecs[1] = mk(1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 5'd5,  1'b1, 8'hA5, 1'b0, 1'b0);
    vecs[2] = mk(1'b0, 1'b1, 5'd10, 8'hC3, 1'b1, 5'd5,  1'b1, 8'hA5, 1'b0, 1'b0);
    vecs[3] = mk(1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 5'd10, 1'b1, 8'hC3, 1'b0, 1'b0);
    vecs[4] = mk(1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 5'd0,  1'b0, 8'hC3, 1'b0, 1'b0);
    vecs[5] = mk(1'b1, 1'b1, 5'd5,  8'h00, 1'b1, 5'd5,  1'b0, 8'hC3, 1'b0, 1'b0);
    vecs[6] = mk(1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 5'd5,  1'b1, 8'hA5, 1'b0, 1'b0);
    vecs[7] = mk(1'b0, 1'b1, 5'd31, 8'h5A, 1'b1, 5'd0,  1'b1, 8'h00, 1'b0, 1'b1);
    vecs[8] = mk(1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 5'd31, 1'b1, 8'h5A, 1'b0, 1'b1);
    vecs[9] = mk(1'b0, 1'b1, 5'd10, 8'h0F, 1'b1, 5'd10, 1'b1, 8'h0F, 1'b0, 1'b0);

    // Reset values while reset is held.
    idle();
    RST_N = 1'b1;
    #2 RST_N = 1'b0;
    #2;
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_perr", 64'(perr), 64'(0));
    check("rst_busy", 64'(busy), 64'(1));

    // Post-reset sweep length for both instances.
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    n = 0; n20 = 0; guard = 0;
    while ((busy || busy20) && guard < 100) begin
      if (busy) n++;
      if (busy20) n20++;
      tick();
      guard++;
    end
    check("sweep_len_32", 64'(n), 64'(32));
    check("sweep_len_20", 64'(n20), 64'(20));

    // Every word reads back zero after the sweep.
    for (int i = 0; i < 32; i++) begin
      CS = 1'b0; RE = 1'b1; RADDR = 5'(i);
      exp_q.push_back(8'h00);
      tick();
      check("zero_rvalid", 64'(rvalid), 64'(1));
      check("zero_rdata", 64'(rdata), 64'(exp_q.pop_front()));
    end
    idle();
    tick();

    // Table of single-cycle vectors.
    for (int i = 0; i < 10; i++) begin
      CS = vecs[i].cs; WE = vecs[i].we; WADDR = vecs[i].waddr; WDATA = vecs[i].wdata;
      RE = vecs[i].re; RADDR = vecs[i].raddr; CLR = 1'b0; PINJ = 1'b0;
      tick();
      check($sformatf("vec%0d_rvalid", i), 64'(rvalid), 64'(vecs[i].exp_rvalid));
      check($sformatf("vec%0d_rdata", i), 64'(rdata), 64'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_err20", i), 64'(err20), 64'(vecs[i].exp_err20));
      check($sformatf("vec%0d_perr", i), 64'(perr), 64'(0));
    end
    idle();
    tick();
    check("err20_one_cycle", 64'(err20), 64'(0));

    // Out-of-range write then read on the DEPTH=20 instance.
    write(5'd25, 8'hFF, 1'b0);
    check("oor_wr_err20", 64'(err20), 64'(1));
    check("oor_wr_err", 64'(err), 64'(0));
    CS = 1'b0; RE = 1'b1; RADDR = 5'd25;
    tick();
    check("oor_rd_err20", 64'(err20), 64'(1));
    check("oor_rd_rvalid20", 64'(rvalid20), 64'(1));
    check("oor_rd_rdata20", 64'(rdata20), 64'(0));
    check("inrange_rd_rdata", 64'(rdata), 64'(8'hFF));
    idle();
    tick();
    check("oor_err20_drop", 64'(err20), 64'(0));

    // Parity inject, then a clean rewrite.
    write(5'd3, 8'h01, 1'b1);
    read_check("par_inj", 5'd3, 8'h01);
    check("par_inj_perr", 64'(perr), 64'(PAR));
    write(5'd3, 8'h01, 1'b0);
    read_check("par_clean", 5'd3, 8'h01);
    check("par_clean_perr", 64'(perr), 64'(0));

    // CLR with a simultaneous write; accesses during the sweep are ignored.
    write(5'd7, 8'h3C, 1'b0);
    CS = 1'b0; CLR = 1'b1; WE = 1'b1; WADDR = 5'd8; WDATA = 8'h99;
    tick();
    check("clr_busy", 64'(busy), 64'(1));
    CLR = 1'b0; WE = 1'b1; WADDR = 5'd7; WDATA = 8'hEE; RE = 1'b1; RADDR = 5'd7;
    n = 0; bad = 1'b0;
    while (busy && n < 100) begin
      tick();
      n++;
      if (rvalid || err) bad = 1'b1;
    end
    idle();
    check("clr_sweep_len", 64'(n), 64'(32));
    check("clr_quiet_outputs", 64'(bad), 64'(0));
    read_check("clr_addr7", 5'd7, 8'h00);
    read_check("clr_addr8", 5'd8, 8'h00);
    read_check("clr_addr5", 5'd5, 8'h00);

    // Reset in the middle of a sweep.
    write(5'd3, 8'h01, 1'b0);
    read_check("pre_rst", 5'd3, 8'h01);
    CS = 1'b0; CLR = 1'b1;
    tick();
    idle();
    repeat (10) tick();
    check("mid_busy", 64'(busy), 64'(1));
    check("mid_rdata_held", 64'(rdata), 64'(8'h01));
    RST_N = 1'b0;
    #1;
    check("mid_rst_rdata", 64'(rdata), 64'(0));
    check("mid_rst_rvalid", 64'(rvalid), 64'(0));
    check("mid_rst_err", 64'(err), 64'(0));
    check("mid_rst_perr", 64'(perr), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(1));
    @(posedge CLK);
    #1 RST_N = 1'b1;
    count_busy(n);
    check("mid_rst_sweep_len", 64'(n), 64'(32));
    read_check("post_rst_addr3", 5'd3, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/reg_file_2p.md
REG_FILE_2P -- requirements
Module: reg_file_2p

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 32, meaning number of words (2..1024, need not be a power of 2).
REQ-003 SHALL have parameter AW, default $clog2(DEPTH), meaning address width; it is derived and not overridden.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port CS, input, 1 bit: active-low chip select; when it is high, WE, RE and CLR are ignored.
REQ-007 SHALL have port WE, input, 1 bit: write request.
REQ-008 SHALL have port WADDR, input, AW bits: write address.
REQ-009 SHALL have port WDATA, input, WIDTH bits: write data.
REQ-010 SHALL have port RE, input, 1 bit: read request.
REQ-011 SHALL have port RADDR, input, AW bits: read address.
REQ-012 SHALL have port CLR, input, 1 bit: single-cycle request to zero every word.
REQ-013 SHALL have port PINJ, input, 1 bit: parity-error inject, qualified by WE.
REQ-014 SHALL have port RDATA, output, WIDTH bits: registered read data.
REQ-015 SHALL have port RVALID, output, 1 bit: RDATA is valid this cycle.
REQ-016 SHALL have port BUSY, output, 1 bit: a clear sweep is in progress.
REQ-017 SHALL have port ERR, output, 1 bit: one-cycle pulse flagging an out-of-range access.
REQ-018 SHALL have port PERR, output, 1 bit: parity mismatch on the current RDATA.

Function
REQ-019 SHALL use FSM states CLEARING and READY; reset enters CLEARING with the sweep counter at 0.
REQ-020 In CLEARING, the block SHALL write zero to word[counter] each cycle; after word DEPTH-1 it SHALL enter READY; BUSY SHALL be 1 throughout CLEARING and only then.
REQ-021 In READY, CLR=1 with CS=0 SHALL restart CLEARING at counter 0 on the next cycle.
REQ-022 While BUSY=1, WE, RE and CLR SHALL be ignored, and RVALID and ERR SHALL stay 0.
REQ-023 In READY, CS=0 with WE=1 and WADDR<DEPTH SHALL write WDATA into word[WADDR] at the clock edge.
REQ-024 In READY, CS=0 with RE=1 and RADDR<DEPTH SHALL drive RDATA=word[RADDR] and RVALID=1 exactly one cycle later.
REQ-025 A read and a write to the same address in the same cycle SHALL return the new WDATA (write-first bypass).
REQ-026 A read and a write to different addresses in the same cycle SHALL both complete; the read returns the old contents.
REQ-027 An access with WADDR>=DEPTH (with WE=1) or RADDR>=DEPTH (with RE=1) SHALL pulse ERR for one cycle, one cycle after the request.
REQ-028 An out-of-range write SHALL leave the array unchanged.
REQ-029 An out-of-range read SHALL give RDATA=0 and RVALID=1.
REQ-030 When no valid read was issued the previous cycle, RVALID SHALL be 0 and RDATA SHALL hold its last value.
REQ-031 CLR and WE in the same READY cycle: the write SHALL be performed and then cleared by the sweep.

Reset
REQ-032 RST_N low SHALL immediately force RDATA=0, RVALID=0, ERR=0, PERR=0, BUSY=1, state=CLEARING and counter=0.
REQ-033 Array contents SHALL NOT be asynchronously reset; they become zero only through the sweep.
REQ-034 Reset asserted mid-sweep or mid-read SHALL abort the operation and restart the sweep at word 0.

Configuration
REQ-035 With macro REG_FILE_2P_PARITY_EN defined, each word SHALL store an extra even-parity bit.
REQ-036 With REG_FILE_2P_PARITY_EN defined, a write with PINJ=1 SHALL store the inverted parity bit.
REQ-037 With REG_FILE_2P_PARITY_EN defined, PERR SHALL be 1 alongside RVALID whenever the stored parity mismatches RDATA.
REQ-038 With REG_FILE_2P_PARITY_EN defined, the sweep SHALL write correct parity (0) for each zeroed word.
REQ-039 With REG_FILE_2P_PARITY_EN undefined, there SHALL be no parity storage, PINJ SHALL be ignored and PERR SHALL be tied to 0.

Structure
REQ-040 A shared package reg_file_pkg SHALL hold the FSM state enumeration (CLEARING, READY) and the default WIDTH/DEPTH constants.
REQ-041 The sweep counter and FSM SHALL live in one sub-module, reg_file_clr_seq, with ports CLK, RST_N, start, busy and addr.
REQ-042 The array and the read path SHALL stay in reg_file_2p.

Verification
REQ-043 Release reset with DEPTH=32 -> BUSY=1 for exactly 32 cycles; then RE to addresses 0..31 -> RDATA=0 and RVALID=1 each cycle after the request.
REQ-044 WE with WADDR=5, WDATA=8'hA5 and, in the same cycle, RE with RADDR=5 -> next cycle RDATA=8'hA5, RVALID=1.
REQ-045 With DEPTH=20: WE with WADDR=25, WDATA=8'hFF -> ERR pulses once; then RE with RADDR=25 -> RDATA=0, ERR pulses again.
REQ-046 Write 8'h3C to address 7, then pulse CLR -> BUSY=1 for 32 cycles, writes during the sweep are ignored, and a later read of address 7 returns 0.
REQ-047 With REG_FILE_2P_PARITY_EN defined: write 8'h01 to address 3 with PINJ=1, then read address 3 -> RDATA=8'h01 and PERR=1; rewrite with PINJ=0 -> PERR=0.
REQ-048 Assert RST_N low at sweep count 10 -> outputs are at reset values immediately, and after release BUSY lasts a full 32 cycles.
